// File: rtl/node_eject.sv
// Ejection buffer between the network and a node's core: dest filter,
// FWFT FIFO, drop/misroute accounting and saturating status counters.
module node_eject #(
  parameter int NUMNODES = 8,
  parameter int NODE_ID  = 0,
  parameter int PKT_W    = 576,
  parameter int DEPTH    = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             pkt_in_valid,
  input  logic [PKT_W-1:0] pkt_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PKT_W-1:0] out_pkt,
  output logic             almost_full,
  output logic [15:0]      rx_count,
  output logic [15:0]      drop_count,
  output logic [15:0]      misroute_count,
  output logic             misroute_err,
  output logic [7:0]       last_src
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [7:0] ID = 8'(NODE_ID);
  localparam logic [AW:0] FULL_OCC = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_OCC = (AW+1)'(DEPTH - 1);
  localparam logic [15:0] SAT = 16'hFFFF;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("node_eject: DEPTH must be a power of two >= 2");
  end
  if (NODE_ID < 0 || NODE_ID >= NUMNODES) begin : g_bad_id
    $error("node_eject: NODE_ID out of range");
  end

  logic [PKT_W-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0] occ;

  logic hit;
  logic miss;
  logic full;
  logic pop;
  logic push;
  logic drop;

  assign hit  = pkt_in_valid && (pkt_in[7:0] == ID);
  assign miss = pkt_in_valid && (pkt_in[7:0] != ID);
  assign full = (occ == FULL_OCC);
  assign pop  = out_valid && out_ready;
  // A pop frees the head slot on the same edge, so a full buffer still takes the packet
  assign push = hit && (!full || pop);
  assign drop = hit && full && !pop;

  assign out_valid   = (occ != '0);
  assign almost_full = (occ >= AF_OCC);
  assign out_pkt     = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (push && !reset) begin
      mem[wr_ptr] <= pkt_in;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr         <= '0;
      wr_ptr         <= '0;
      occ            <= '0;
      rx_count       <= '0;
      drop_count     <= '0;
      misroute_count <= '0;
      misroute_err   <= 1'b0;
      last_src       <= '0;
    end else begin
      if (push) begin
        wr_ptr   <= wr_ptr + 1'b1;
        last_src <= pkt_in[15:8];
        if (rx_count != SAT) rx_count <= rx_count + 16'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        occ <= occ + 1'b1;
      end else if (pop && !push) begin
        occ <= occ - 1'b1;
      end
      if (drop && drop_count != SAT) begin
        drop_count <= drop_count + 16'd1;
      end
      if (miss) begin
        misroute_err <= 1'b1;
        if (misroute_count != SAT) misroute_count <= misroute_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_node_eject.sv
// Scoreboard bench for node_eject: queue reference model, directed
// scenarios, random traffic and misroute counter saturation.
module tb_node_eject;

  localparam int PKT_W = 64;
  localparam int DEPTH = 4;
  localparam int ID = 3;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic pkt_in_valid = 1'b0;
  logic [PKT_W-1:0] pkt_in = '0;
  logic out_ready = 1'b0;
  logic out_valid;
  logic [PKT_W-1:0] out_pkt;
  logic almost_full;
  logic [15:0] rx_count;
  logic [15:0] drop_count;
  logic [15:0] misroute_count;
  logic misroute_err;
  logic [7:0] last_src;

  node_eject #(
    .NUMNODES(8), .NODE_ID(ID), .PKT_W(PKT_W), .DEPTH(DEPTH)
  ) dut (
    .clock(clock), .reset(reset),
    .pkt_in_valid(pkt_in_valid), .pkt_in(pkt_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_pkt(out_pkt),
    .almost_full(almost_full), .rx_count(rx_count),
    .drop_count(drop_count), .misroute_count(misroute_count),
    .misroute_err(misroute_err), .last_src(last_src)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  logic [PKT_W-1:0] exp_q[$];
  int m_occ = 0;
  int m_rx = 0;
  int m_drop = 0;
  int m_mis = 0;
  bit m_err = 0;
  int m_src = 0;
  bit started = 0;

  function automatic int sat_inc(int v);
    return (v >= 65535) ? 65535 : v + 1;
  endfunction

  task automatic chk(string name, longint act, longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
    end
  endtask

  // Reference model: applies the inputs sampled at each rising edge
  always @(posedge clock) begin
    if (reset) begin
      m_occ = 0; m_rx = 0; m_drop = 0; m_mis = 0;
      m_err = 0; m_src = 0;
      exp_q.delete();
      started = 1;
    end else if (started) begin
      bit popm, acc;
      popm = (m_occ != 0) && out_ready;
      acc = 0;
      if (pkt_in_valid) begin
        if (pkt_in[7:0] == 8'(ID)) begin
          if (m_occ < DEPTH || popm) begin
            acc = 1;
            exp_q.push_back(pkt_in);
            m_rx = sat_inc(m_rx);
            m_src = int'(pkt_in[15:8]);
          end else begin
            m_drop = sat_inc(m_drop);
          end
        end else begin
          m_mis = sat_inc(m_mis);
          m_err = 1;
        end
      end
      m_occ = m_occ + int'(acc) - int'(popm);
    end
  end

  // Monitor: pops the scoreboard whenever the DUT completes a handshake
  always @(negedge clock) begin
    if (started) begin
      chk("out_valid", out_valid, m_occ != 0);
      chk("almost_full", almost_full, m_occ >= DEPTH - 1);
      chk("rx_count", rx_count, m_rx);
      chk("drop_count", drop_count, m_drop);
      chk("misroute_count", misroute_count, m_mis);
      chk("misroute_err", misroute_err, m_err);
      chk("last_src", last_src, m_src);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL head at %0t: got %0h expected no packet", $time, out_pkt);
        end else begin
          chk("head", out_pkt, exp_q[0]);
          if (out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  function automatic logic [PKT_W-1:0] mk(int dest, int src);
    logic [PKT_W-1:0] p;
    p = {$urandom, $urandom};
    p[7:0] = 8'(dest);
    p[15:8] = 8'(src);
    return p;
  endfunction

  task automatic step(input logic v, input logic [PKT_W-1:0] p,
                      input logic r, input logic rst);
    pkt_in_valid = v;
    pkt_in = p;
    out_ready = r;
    reset = rst;
    @(posedge clock);
    #1;
  endtask

  task automatic idle(int n, logic r);
    for (int i = 0; i < n; i++) step(1'b0, mk($urandom, $urandom), r, 1'b0);
  endtask

  initial begin
    int dst;
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1);
    // single packet
    step(1'b1, mk(ID, 5), 1'b0, 1'b0);
    idle(2, 1'b0);
    idle(2, 1'b1);
    // fill and overflow
    for (int i = 0; i < 5; i++) step(1'b1, mk(ID, 16 + i), 1'b0, 1'b0);
    idle(6, 1'b1);
    // full with simultaneous push and pop
    for (int i = 0; i < 4; i++) step(1'b1, mk(ID, 32 + i), 1'b0, 1'b0);
    step(1'b1, mk(ID, 40), 1'b1, 1'b0);
    idle(1, 1'b0);
    idle(6, 1'b1);
    // misroute
    step(1'b1, mk(2, 7), 1'b1, 1'b0);
    idle(3, 1'b1);
    // backpressure
    step(1'b1, mk(ID, 50), 1'b0, 1'b0);
    step(1'b1, mk(ID, 51), 1'b0, 1'b0);
    idle(3, 1'b0);
    idle(3, 1'b1);
    // mid-operation reset
    for (int i = 0; i < 3; i++) step(1'b1, mk(ID, 60 + i), 1'b0, 1'b0);
    step(1'b1, mk(ID, 70), 1'b1, 1'b1);
    step(1'b1, mk(ID, 71), 1'b0, 1'b0);
    idle(3, 1'b1);
    // random traffic
    for (int i = 0; i < 4000; i++) begin
      dst = ($urandom_range(0, 9) < 8) ? ID : $urandom_range(0, 255);
      step($urandom_range(0, 99) < 65, mk(dst, $urandom),
           $urandom_range(0, 99) < ((i / 500) % 2 ? 30 : 75),
           $urandom_range(0, 999) == 0);
    end
    // misroute counter saturation with ignored pkt_in when not valid
    for (int i = 0; i < 65540; i++) begin
      step(i % 2 == 0 || i > 65000, mk(ID + 1, i), 1'b1, 1'b0);
    end
    for (int i = 0; i < 65540 / 2; i++) begin
      step(1'b1, mk(ID + 2, i), 1'b1, 1'b0);
    end
    idle(3, 1'b1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/node_eject.md
NODE_EJECT -- requirements
Module: node_eject

Interface
REQ-001 SHALL have parameter NUMNODES, default 8: number of network nodes.
REQ-002 SHALL have parameter NODE_ID, default 0: index of the node this instance serves.
REQ-003 SHALL have parameter PKT_W, default 576: packet width in bits; dest = bits [7:0], src = bits [15:8].
REQ-004 SHALL have parameter DEPTH, default 4: ejection buffer entries, a power of two and at least 2.
REQ-005 SHALL have port clock, input, 1: sole clock, rising-edge.
REQ-006 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port pkt_in_valid, input, 1: a network packet arrives this cycle (the node's received strobe).
REQ-008 SHALL have port pkt_in, input, PKT_W: arriving packet (the node's received packet).
REQ-009 SHALL have port out_valid, output, 1: buffer head is valid toward the core.
REQ-010 SHALL have port out_ready, input, 1: core accepts the head this cycle.
REQ-011 SHALL have port out_pkt, output, PKT_W: buffer head packet.
REQ-012 SHALL have port almost_full, output, 1: occupancy >= DEPTH-1.
REQ-013 SHALL have port rx_count, output, 16: packets accepted into the buffer, saturating.
REQ-014 SHALL have port drop_count, output, 16: packets dropped because the buffer was full, saturating.
REQ-015 SHALL have port misroute_count, output, 16: packets discarded for wrong dest, saturating.
REQ-016 SHALL have port misroute_err, output, 1: sticky; set on the first misroute.
REQ-017 SHALL have port last_src, output, 8: src field of the most recently accepted packet.

Function
REQ-018 SHALL act as a first-word-fall-through FIFO: a packet accepted in cycle N appears on out_pkt with out_valid=1 in cycle N+1 when the buffer was empty.
REQ-019 SHALL complete a pop on any cycle where out_valid && out_ready, advancing the head on the following edge.
REQ-020 SHALL hold out_valid and out_pkt stable while out_valid=1 and out_ready=0.
REQ-021 SHALL accept a packet only when pkt_in_valid=1, dest == NODE_ID[7:0], and a free slot exists.
REQ-022 SHALL discard a pkt_in_valid packet with dest != NODE_ID, increment misroute_count and set misroute_err; there is no push and no drop count.
REQ-023 SHALL, when full with no pop that cycle, drop a correctly addressed packet and increment drop_count.
REQ-024 SHALL, when full with a pop in the same cycle, accept the arriving packet with no drop; occupancy stays DEPTH.
REQ-025 SHALL, when empty with a push in the same cycle, not pop; out_valid=0 that cycle (no bypass).
REQ-026 SHALL track occupancy 0..DEPTH with wrap-around read and write pointers modulo DEPTH.
REQ-027 SHALL update occupancy by +1 on push only, -1 on pop only, and 0 on both or neither.
REQ-028 SHALL make out_valid = (occupancy != 0) and almost_full a combinational decode of occupancy.
REQ-029 SHALL increment rx_count on each accepted push and update last_src in the same cycle.
REQ-030 SHALL have all counters saturate at 16'hFFFF with no wrap.
REQ-031 SHALL ignore pkt_in while pkt_in_valid=0.

Reset
REQ-032 SHALL, with reset=1 at a clock edge, clear occupancy and pointers, making out_valid=0 and almost_full=0.
REQ-033 SHALL, on the same reset, clear rx_count, drop_count, misroute_count, last_src and misroute_err to 0.
REQ-034 SHALL ignore pkt_in_valid and out_ready in a reset cycle; buffered packets are lost.
REQ-035 SHALL leave out_pkt contents don't-care after reset while out_valid=0.

Verification
REQ-036 SHALL cover single packet: NODE_ID=3, push dest=3 src=5 at cycle 0 -> out_valid=1 at cycle 1, last_src=5, rx_count=1.
REQ-037 SHALL cover fill and overflow: DEPTH=4, out_ready=0, 5 valid pushes -> almost_full=1 after the 3rd, drop_count=1, first 4 drained in order.
REQ-038 SHALL cover full with simultaneous push and pop: 4 packets buffered, then push+pop together -> drop_count=0, occupancy=4, order preserved.
REQ-039 SHALL cover misroute: NODE_ID=3, push dest=2 -> misroute_count=1, misroute_err=1 and stays 1, out_valid stays 0.
REQ-040 SHALL cover backpressure: head held 3 cycles with out_ready=0 -> out_pkt stable; pop on the 4th cycle -> next entry shown.
REQ-041 SHALL cover mid-operation reset: 3 packets buffered, reset for 1 cycle -> all outputs 0, out_valid=0, next push works normally.
